// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core and its seven-segment driver.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BCD_W      = DIGIT_W * NUM_DIGITS;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned AN_W       = 4;
  localparam int unsigned IDX_W      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_e;

  // Element i enables digit i; digit 0 is the rightmost.
  localparam logic [NUM_DIGITS-1:0][AN_W-1:0] AN_ONE_COLD =
    {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // {g,f,e,d,c,b,a}, active-low; non-decimal codes blank the digit.
  function automatic logic [SEG_W-1:0] seg_decode(input logic [DIGIT_W-1:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Ripple-carry BCD increment; 9999 rolls over to 0000.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic             carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (r[i*DIGIT_W +: DIGIT_W] == DIGIT_W'(9)) begin
          r[i*DIGIT_W +: DIGIT_W] = '0;
        end else begin
          r[i*DIGIT_W +: DIGIT_W] = r[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_7seg_if.sv
// Board-facing signal bundle: divided clocks and buttons in, display and status out.
interface stopwatch_7seg_if;
  import stopwatch_pkg::*;

  logic                in_clk_100Hz;
  logic                in_clk_1kHz;
  logic                btn_start_stop;
  logic                btn_clear;
  logic [SEG_W-1:0]    seg;
  logic                dp;
  logic [AN_W-1:0]     an;
  logic                running;
  logic [BCD_W-1:0]    bcd;

  modport master (
    output in_clk_100Hz, in_clk_1kHz, btn_start_stop, btn_clear,
    input  seg, dp, an, running, bcd
  );

  modport slave (
    input  in_clk_100Hz, in_clk_1kHz, btn_start_stop, btn_clear,
    output seg, dp, an, running, bcd
  );
endinterface

// File: rtl/btn_debounce.sv
// Pushbutton synchronizer + debouncer; emits a one-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned DB_W            = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  logic [1:0]      sync_q, sync_d;
  logic            acc_q, acc_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  // Count only while the synced level disagrees with the accepted one.
  always_comb begin
    sync_d  = {sync_q[0], btn_i};
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync_q[1] == acc_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      acc_d   = sync_q[1];
      cnt_d   = '0;
      press_d = sync_q[1];
    end else begin
      cnt_d = cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_7seg.sv
// BCD stopwatch (00.00-99.99) driven by divider ticks, with a 4-digit multiplexed display.
module stopwatch_7seg
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned DB_W            = 20
) (
  input  logic             incoming_CLK100MHZ,
  input  logic             incoming_RSTN,
  stopwatch_7seg_if.slave  bus
);

  logic [1:0]       s100_q, s100_d, s1k_q, s1k_d;
  logic             h100_q, h100_d, h1k_q, h1k_d;
  logic             tick100_c, tick1k_c;
  logic             ss_press, clr_press;

  sw_state_e        state_q, state_d;
  logic [BCD_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [AN_W-1:0]  an_q, an_d;
  logic             dp_q, dp_d;
  logic             running_q, running_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_start_stop (
    .clk     (incoming_CLK100MHZ),
    .rst_n   (incoming_RSTN),
    .btn_i   (bus.btn_start_stop),
    .press_o (ss_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_clear (
    .clk     (incoming_CLK100MHZ),
    .rst_n   (incoming_RSTN),
    .btn_i   (bus.btn_clear),
    .press_o (clr_press)
  );

  // Divided clocks: two sync stages plus history flop for rising-edge detect.
  always_comb begin
    s100_d    = {s100_q[0], bus.in_clk_100Hz};
    s1k_d     = {s1k_q[0], bus.in_clk_1kHz};
    h100_d    = s100_q[1];
    h1k_d     = s1k_q[1];
    tick100_c = s100_q[1] & ~h100_q;
    tick1k_c  = s1k_q[1] & ~h1k_q;
  end

  // Control FSM, counter and scan; display outputs follow next-state so they switch together.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (tick1k_c) idx_d = idx_q + IDX_W'(1);
    if (clr_press) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE:    if (ss_press) state_d = RUN;
        RUN: begin
          if (tick100_c) cnt_d = bcd_inc(cnt_q);
          if (ss_press) state_d = PAUSE;
        end
        PAUSE:   if (ss_press) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
    seg_d     = seg_decode(cnt_d[{idx_d, 2'b00} +: DIGIT_W]);
    an_d      = AN_ONE_COLD[idx_d];
    dp_d      = (idx_d != IDX_W'(2));
  end

  always_ff @(posedge incoming_CLK100MHZ or negedge incoming_RSTN) begin
    if (!incoming_RSTN) begin
      s100_q    <= '0;
      s1k_q     <= '0;
      h100_q    <= 1'b0;
      h1k_q     <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      seg_q     <= 7'b1000000;
      an_q      <= 4'b1110;
      dp_q      <= 1'b1;
      running_q <= 1'b0;
    end else begin
      s100_q    <= s100_d;
      s1k_q     <= s1k_d;
      h100_q    <= h100_d;
      h1k_q     <= h1k_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
      running_q <= running_d;
    end
  end

  assign bus.seg     = seg_q;
  assign bus.an      = an_q;
  assign bus.dp      = dp_q;
  assign bus.running = running_q;
  assign bus.bcd     = cnt_q;

endmodule

// File: tb/tb_stopwatch_7seg.sv
// Randomized self-checking bench for stopwatch_7seg against a behavioural stopwatch model.
module tb_stopwatch_7seg;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stopwatch_7seg_if bus();

  stopwatch_7seg #(.DEBOUNCE_CYCLES(4), .DB_W(3)) dut (
    .incoming_CLK100MHZ (clk),
    .incoming_RSTN      (rst_n),
    .bus                (bus)
  );

  localparam logic [6:0] SEG_REF [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                          7'b0000000, 7'b0010000};
  localparam int POW10 [4] = '{1, 10, 100, 1000};

  int n_cmp = 0;
  int n_err = 0;

  // Model: elapsed hundredths, mode (0 idle, 1 running, 2 paused), scan position.
  int m_cnt   = 0;
  int m_state = 0;
  int m_idx   = 0;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic tick100(input int hi, input int lo);
    @(negedge clk) bus.in_clk_100Hz = 1'b1;
    repeat (hi) @(negedge clk);
    bus.in_clk_100Hz = 1'b0;
    repeat (lo) @(negedge clk);
    if (m_state == 1) m_cnt = (m_cnt + 1) % 10000;
  endtask

  task automatic tick1k();
    @(negedge clk) bus.in_clk_1kHz = 1'b1;
    repeat (2) @(negedge clk);
    bus.in_clk_1kHz = 1'b0;
    repeat (3) @(negedge clk);
    m_idx = (m_idx + 1) % 4;
  endtask

  task automatic press(input bit ss, input bit clr);
    @(negedge clk);
    bus.btn_start_stop = ss;
    bus.btn_clear      = clr;
    repeat (10) @(negedge clk);
    bus.btn_start_stop = 1'b0;
    bus.btn_clear      = 1'b0;
    repeat (12) @(negedge clk);
    if (clr) begin
      m_state = 0;
      m_cnt   = 0;
    end else if (ss) begin
      m_state = (m_state == 1) ? 2 : 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 5;
    if (bus.an !== 4'b1110) begin n_err++; $display("FAIL reset_an: got %b want 1110", bus.an); end
    if (bus.seg !== 7'b1000000) begin n_err++; $display("FAIL reset_seg: got %b want 1000000", bus.seg); end
    if (bus.dp !== 1'b1) begin n_err++; $display("FAIL reset_dp: got %b want 1", bus.dp); end
    if (bus.running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b want 0", bus.running); end
    if (bus.bcd !== 16'h0000) begin n_err++; $display("FAIL reset_bcd: got %h want 0000", bus.bcd); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp += 2;
    if (bus.bcd !== 16'h0000) begin n_err++; $display("FAIL post_reset_bcd: got %h want 0000", bus.bcd); end
    if (bus.running !== 1'b0) begin n_err++; $display("FAIL post_reset_running: got %b want 0", bus.running); end
  endtask

  task automatic test_count();
    press(1'b1, 1'b0);
    n_cmp++;
    if (bus.running !== 1'b1) begin n_err++; $display("FAIL count_start_running: got %b want 1", bus.running); end
    for (int i = 0; i < 150; i++) tick100($urandom_range(1, 4), $urandom_range(2, 5));
    n_cmp += 2;
    if (bus.bcd !== 16'h0150 || bus.bcd !== to_bcd(m_cnt))
      begin n_err++; $display("FAIL count_150: got %h want 0150 (model %h)", bus.bcd, to_bcd(m_cnt)); end
    if (bus.running !== 1'b1) begin n_err++; $display("FAIL count_running: got %b want 1", bus.running); end
    press(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) tick100($urandom_range(1, 4), $urandom_range(2, 5));
    n_cmp += 2;
    if (bus.bcd !== 16'h0150) begin n_err++; $display("FAIL count_paused_bcd: got %h want 0150", bus.bcd); end
    if (bus.running !== 1'b0) begin n_err++; $display("FAIL count_paused_running: got %b want 0", bus.running); end
  endtask

  task automatic test_random();
    int op;
    press(1'b0, 1'b1);
    for (int it = 0; it < 16; it++) begin
      op = int'($urandom_range(0, 5));
      if (op <= 2) begin
        for (int t = 0; t < int'($urandom_range(1, 40)); t++)
          tick100($urandom_range(1, 3), $urandom_range(2, 4));
      end else if (op <= 4) begin
        press(1'b1, 1'b0);
      end else begin
        press(1'b0, 1'b1);
      end
      n_cmp += 3;
      if (bus.bcd !== to_bcd(m_cnt))
        begin n_err++; $display("FAIL random_bcd[%0d]: got %h want %h", it, bus.bcd, to_bcd(m_cnt)); end
      if (bus.running !== (m_state == 1))
        begin n_err++; $display("FAIL random_running[%0d]: got %b want %b", it, bus.running, m_state == 1); end
      if (bus.seg !== SEG_REF[(m_cnt / POW10[m_idx]) % 10])
        begin n_err++; $display("FAIL random_seg[%0d]: got %b want %b", it, bus.seg, SEG_REF[(m_cnt / POW10[m_idx]) % 10]); end
    end
  endtask

  task automatic test_wrap();
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    for (int i = 0; i < 9999; i++) tick100(1, 2);
    n_cmp++;
    if (bus.bcd !== 16'h9999) begin n_err++; $display("FAIL wrap_9999: got %h want 9999", bus.bcd); end
    tick100(1, 2);
    n_cmp += 2;
    if (bus.bcd !== 16'h0000 || m_cnt != 0) begin n_err++; $display("FAIL wrap_0000: got %h want 0000", bus.bcd); end
    if (bus.running !== 1'b1) begin n_err++; $display("FAIL wrap_running: got %b want 1", bus.running); end
  endtask

  task automatic test_debounce();
    press(1'b0, 1'b1);
    @(negedge clk) bus.btn_start_stop = 1'b1;
    repeat (2) @(negedge clk);
    bus.btn_start_stop = 1'b0;
    repeat (15) @(negedge clk);
    n_cmp++;
    if (bus.running !== 1'b0) begin n_err++; $display("FAIL debounce_glitch: running got %b want 0", bus.running); end
    press(1'b1, 1'b0);
    n_cmp++;
    if (bus.running !== 1'b1) begin n_err++; $display("FAIL debounce_hold: running got %b want 1", bus.running); end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (bus.running !== 1'b1) begin n_err++; $display("FAIL debounce_single: running got %b want 1", bus.running); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 42; i++) tick100($urandom_range(1, 3), $urandom_range(2, 4));
    n_cmp++;
    if (bus.bcd !== 16'h0042) begin n_err++; $display("FAIL simul_pre_bcd: got %h want 0042", bus.bcd); end
    press(1'b1, 1'b1);
    n_cmp += 2;
    if (bus.bcd !== 16'h0000) begin n_err++; $display("FAIL simul_bcd: got %h want 0000", bus.bcd); end
    if (bus.running !== 1'b0) begin n_err++; $display("FAIL simul_running: got %b want 0", bus.running); end
  endtask

  task automatic test_scan();
    logic [3:0] exp_an  [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic [6:0] exp_seg [4] = '{7'b0110000, 7'b0100100, 7'b1111001, 7'b0011001};
    logic       exp_dp  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    press(1'b1, 1'b0);
    for (int i = 0; i < 1234; i++) tick100(1, 2);
    press(1'b1, 1'b0);
    n_cmp += 3;
    if (bus.bcd !== 16'h1234) begin n_err++; $display("FAIL scan_bcd: got %h want 1234", bus.bcd); end
    if (bus.an !== 4'b1110) begin n_err++; $display("FAIL scan_idle_an: got %b want 1110", bus.an); end
    if (bus.seg !== SEG_REF[m_cnt % 10]) begin n_err++; $display("FAIL scan_idle_seg: got %b want %b", bus.seg, SEG_REF[m_cnt % 10]); end
    for (int k = 0; k < 4; k++) begin
      tick1k();
      n_cmp += 3;
      if (bus.an !== exp_an[k]) begin n_err++; $display("FAIL scan_an[%0d]: got %b want %b", k, bus.an, exp_an[k]); end
      if (bus.seg !== exp_seg[k]) begin n_err++; $display("FAIL scan_seg[%0d]: got %b want %b", k, bus.seg, exp_seg[k]); end
      if (bus.dp !== exp_dp[k]) begin n_err++; $display("FAIL scan_dp[%0d]: got %b want %b", k, bus.dp, exp_dp[k]); end
    end
  endtask

  task automatic test_reset_mid();
    press(1'b1, 1'b0);
    tick1k();
    for (int i = 0; i < 37; i++) tick100($urandom_range(1, 3), $urandom_range(2, 4));
    @(negedge clk) bus.in_clk_100Hz = 1'b1;
    rst_n = 1'b0;
    #1;
    n_cmp += 5;
    if (bus.an !== 4'b1110) begin n_err++; $display("FAIL midrst_an: got %b want 1110", bus.an); end
    if (bus.seg !== 7'b1000000) begin n_err++; $display("FAIL midrst_seg: got %b want 1000000", bus.seg); end
    if (bus.dp !== 1'b1) begin n_err++; $display("FAIL midrst_dp: got %b want 1", bus.dp); end
    if (bus.running !== 1'b0) begin n_err++; $display("FAIL midrst_running: got %b want 0", bus.running); end
    if (bus.bcd !== 16'h0000) begin n_err++; $display("FAIL midrst_bcd: got %h want 0000", bus.bcd); end
    bus.in_clk_100Hz = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_cnt = 0; m_state = 0; m_idx = 0;
    repeat (10) @(negedge clk);
    n_cmp += 3;
    if (bus.bcd !== 16'h0000) begin n_err++; $display("FAIL midrst_after_bcd: got %h want 0000", bus.bcd); end
    if (bus.running !== 1'b0) begin n_err++; $display("FAIL midrst_after_running: got %b want 0", bus.running); end
    if (bus.an !== 4'b1110) begin n_err++; $display("FAIL midrst_after_an: got %b want 1110", bus.an); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_clk_100Hz   = 1'b0;
    bus.in_clk_1kHz    = 1'b0;
    bus.btn_start_stop = 1'b0;
    bus.btn_clear      = 1'b0;
    test_reset();
    test_count();
    test_random();
    test_wrap();
    test_debounce();
    test_simultaneous();
    test_reset_mid();
    test_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
